// File: rtl/bp_be_div_sequencer_pkg.sv
// Shared types for the BE iterative divide/remainder unit.
package bp_be_div_sequencer_pkg;

  typedef enum logic [2:0] {
    e_div  = 3'b100,
    e_divu = 3'b101,
    e_rem  = 3'b110,
    e_remu = 3'b111
  } rv64_div_op_e;

  typedef enum logic [1:0] {
    e_idle,
    e_calc,
    e_fix,
    e_done
  } bp_be_div_state_e;

  // funct3[0] clear selects the signed flavours (DIV/REM).
  function automatic logic div_op_is_signed(rv64_div_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/bp_be_div_sequencer_if.sv
// Issue/result bundle between the BE long-latency pipe and the divide unit.
interface bp_be_div_sequencer_if #(
  parameter int data_width_p = 64,
  parameter int rd_width_p   = 5
);
  logic                    v_i;
  logic                    ready_o;
  logic [2:0]              funct3_i;
  logic                    word_op_i;
  logic [data_width_p-1:0] rs1_i;
  logic [data_width_p-1:0] rs2_i;
  logic [rd_width_p-1:0]   rd_addr_i;
  logic                    flush_i;
  logic                    v_o;
  logic                    yumi_i;
  logic [data_width_p-1:0] data_o;
  logic [rd_width_p-1:0]   rd_addr_o;

  modport master (
    output v_i, funct3_i, word_op_i, rs1_i, rs2_i, rd_addr_i, flush_i, yumi_i,
    input  ready_o, v_o, data_o, rd_addr_o
  );

  modport slave (
    input  v_i, funct3_i, word_op_i, rs1_i, rs2_i, rd_addr_i, flush_i, yumi_i,
    output ready_o, v_o, data_o, rd_addr_o
  );
endinterface

// File: rtl/bp_be_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract if it fits.
module bp_be_div_step #(
  parameter int data_width_p = 64
) (
  input  logic [data_width_p-1:0] rem,
  input  logic [data_width_p-1:0] quo,
  input  logic [data_width_p-1:0] dvsr,
  output logic [data_width_p-1:0] rem_next,
  output logic [data_width_p-1:0] quo_next
);

  logic [data_width_p:0] shifted;
  logic [data_width_p:0] diff;

  // rem < dvsr on entry, so the 65-bit difference never wraps; its MSB is the borrow.
  always_comb begin
    shifted = {rem, quo[data_width_p-1]};
    diff    = shifted - {1'b0, dvsr};
    if (!diff[data_width_p]) begin
      rem_next = diff[data_width_p-1:0];
      quo_next = {quo[data_width_p-2:0], 1'b1};
    end else begin
      rem_next = shifted[data_width_p-1:0];
      quo_next = {quo[data_width_p-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/bp_be_div_sequencer.sv
// Iterative RV64M DIV/DIVU/REM/REMU(W) unit: one op in flight, valid/yumi result, flushable.
module bp_be_div_sequencer
  import bp_be_div_sequencer_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int rd_width_p   = 5
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bp_be_div_sequencer_if.slave   div_if
);

  localparam int cnt_width_lp = $clog2(data_width_p + 1);
  localparam int half_lp      = data_width_p / 2;

  typedef logic [data_width_p-1:0] word_t;

  bp_be_div_state_e        state_r;
  word_t                   rem_r, quo_r, dvsr_r, data_r;
  logic [rd_width_p-1:0]   rd_r;
  logic [cnt_width_lp-1:0] cnt_r;
  logic                    q_neg_r, r_neg_r, rem_op_r, word_r, ready_r, v_r;

  rv64_div_op_e op;
  logic         is_signed, accept, sgn1, sgn2, div_zero, overflow;
  word_t        ext1, ext2, abs1, abs2, min_val, quo_load;
  word_t        res_special, quo_fix, rem_fix, res_fix, step_rem, step_quo;

  function automatic word_t sext_half(word_t v);
    return {{half_lp{v[half_lp-1]}}, v[half_lp-1:0]};
  endfunction

  always_comb begin
    op        = rv64_div_op_e'(div_if.funct3_i);
    is_signed = div_op_is_signed(op);
    accept    = div_if.v_i & ready_r & ~div_if.flush_i;

    if (div_if.word_op_i) begin
      ext1    = is_signed ? sext_half(div_if.rs1_i) : {{half_lp{1'b0}}, div_if.rs1_i[half_lp-1:0]};
      ext2    = is_signed ? sext_half(div_if.rs2_i) : {{half_lp{1'b0}}, div_if.rs2_i[half_lp-1:0]};
      min_val = {{(half_lp+1){1'b1}}, {(half_lp-1){1'b0}}};
    end else begin
      ext1    = div_if.rs1_i;
      ext2    = div_if.rs2_i;
      min_val = {1'b1, {(data_width_p-1){1'b0}}};
    end

    sgn1     = is_signed & ext1[data_width_p-1];
    sgn2     = is_signed & ext2[data_width_p-1];
    abs1     = sgn1 ? -ext1 : ext1;
    abs2     = sgn2 ? -ext2 : ext2;
    div_zero = (ext2 == '0);
    overflow = is_signed & (ext1 == min_val) & (ext2 == '1);

    // Word ops run half the iterations, so park the dividend in the upper half.
    quo_load = div_if.word_op_i ? {abs1[half_lp-1:0], {half_lp{1'b0}}} : abs1;

    if (div_zero)
      res_special = op[1] ? ext1 : '1;
    else
      res_special = op[1] ? '0 : ext1;
    if (div_if.word_op_i)
      res_special = sext_half(res_special);

    quo_fix = q_neg_r ? -quo_r : quo_r;
    rem_fix = r_neg_r ? -rem_r : rem_r;
    res_fix = rem_op_r ? rem_fix : quo_fix;
    if (word_r)
      res_fix = sext_half(res_fix);
  end

  bp_be_div_step #(.data_width_p(data_width_p)) step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvsr     (dvsr_r),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      ready_r  <= 1'b0;
      v_r      <= 1'b0;
      data_r   <= '0;
      rd_r     <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvsr_r   <= '0;
      cnt_r    <= '0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      rem_op_r <= 1'b0;
      word_r   <= 1'b0;
    end else if (div_if.flush_i) begin
      state_r <= e_idle;
      ready_r <= 1'b1;
      v_r     <= 1'b0;
    end else begin
      case (state_r)
        e_idle: begin
          if (accept) begin
            rd_r     <= div_if.rd_addr_i;
            rem_op_r <= op[1];
            word_r   <= div_if.word_op_i;
            q_neg_r  <= sgn1 ^ sgn2;
            r_neg_r  <= sgn1;
            rem_r    <= '0;
            quo_r    <= quo_load;
            dvsr_r   <= abs2;
            cnt_r    <= div_if.word_op_i ? cnt_width_lp'(half_lp) : cnt_width_lp'(data_width_p);
            ready_r  <= 1'b0;
            if (div_zero | overflow) begin
              data_r  <= res_special;
              v_r     <= 1'b1;
              state_r <= e_done;
            end else begin
              state_r <= e_calc;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        e_calc: begin
          rem_r <= step_rem;
          quo_r <= step_quo;
          cnt_r <= cnt_r - cnt_width_lp'(1);
          if (cnt_r == cnt_width_lp'(1))
            state_r <= e_fix;
        end
        e_fix: begin
          data_r  <= res_fix;
          v_r     <= 1'b1;
          state_r <= e_done;
        end
        e_done: begin
          if (div_if.yumi_i) begin
            v_r     <= 1'b0;
            ready_r <= 1'b1;
            state_r <= e_idle;
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  assign div_if.ready_o   = ready_r;
  assign div_if.v_o       = v_r;
  assign div_if.data_o    = data_r;
  assign div_if.rd_addr_o = rd_r;

  a_div_funct3: assert property (@(posedge clk_i) disable iff (reset_i)
    accept |-> div_if.funct3_i[2]);
  a_yumi_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    div_if.yumi_i |-> v_r);

endmodule
